// File: rtl/spi_ram_streamer_pkg.sv
// spi_ram_streamer_pkg: shared types and default widths for the buffer RAM
// streamer and the buffer RAM wrapper.
package spi_ram_streamer_pkg;

   // Default buffer geometry: 1024 bytes.
   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 8;

   // Burst sequencer states.
   typedef enum logic [2:0] {
      IDLE,    // waiting for a start request
      FETCH,   // address presented, waiting for RAM read data
      LOAD,    // first byte captured into the shift register
      SHIFT,   // SCLK running, bytes shifting out MSB first
      TAIL     // SCLK held low for one half-period before releasing CS_n
   } state_t;

endpackage

// File: rtl/spi_ram_streamer_if.sv
// spi_ram_streamer_if: host handshake, buffer RAM read port and SPI pins of
// the streamer. The master side is the streamer itself; the slave side is
// the host/RAM/SPI target environment around it.
interface spi_ram_streamer_if
   import spi_ram_streamer_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              i_Start;
   logic [ADDR_W-1:0] i_Base_Address;
   logic [ADDR_W:0]   i_Length;
   logic [ADDR_W-1:0] r_Address;
   logic [DATA_W-1:0] r_Data;
   logic              o_Busy;
   logic              o_Done;
   logic              o_SPI_Clk;
   logic              o_SPI_MOSI;
   logic              o_SPI_CS_n;

   modport master (
      input  i_Start, i_Base_Address, i_Length, r_Data,
      output r_Address, o_Busy, o_Done, o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
   );

   modport slave (
      output i_Start, i_Base_Address, i_Length, r_Data,
      input  r_Address, o_Busy, o_Done, o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
   );

endinterface

// File: rtl/spi_ram_streamer_spi_clk_gen.sv
// spi_clk_gen: SPI mode-0 SCLK generator. While enabled, SCLK is low for
// CLKS_PER_HALF_BIT cycles, then high for CLKS_PER_HALF_BIT cycles. The rise
// and fall strobes are high in the cycle whose closing edge toggles SCLK, so
// the owner can update data on the same edge SCLK moves.
module spi_clk_gen #(
   parameter int CLKS_PER_HALF_BIT = 2
) (
   input  logic r_Clk,
   input  logic r_Rst_n,
   input  logic en,
   output logic sclk,
   output logic rise,
   output logic fall
);

   localparam int CNT_W = $clog2(CLKS_PER_HALF_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_HALF_BIT - 1);

   logic [CNT_W-1:0] cnt;
   logic             half_end;

   assign half_end = en && (cnt == HALF_LAST);
   assign rise     = half_end && !sclk;
   assign fall     = half_end && sclk;

   // Half-period counter and SCLK toggle; disabled means SCLK parked low.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking (=) here would create order-dependent logic.
   always_ff @(posedge r_Clk or negedge r_Rst_n) begin
      if (!r_Rst_n) begin
         cnt  <= '0;
         sclk <= 1'b0;
      end else if (!en) begin
         cnt  <= '0;
         sclk <= 1'b0;
      end else if (cnt == HALF_LAST) begin
         cnt  <= '0;
         sclk <= ~sclk;
      end else begin
         cnt  <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/spi_ram_streamer.sv
// spi_ram_streamer: drains a byte range of the buffer RAM through its read
// port and shifts it out as an SPI mode-0 controller, MSB first. The next
// byte is prefetched on the first SCLK rise of the current byte so SCLK runs
// without gaps across byte boundaries.
module spi_ram_streamer
   import spi_ram_streamer_pkg::*;
#(
   parameter int ADDR_W            = DEF_ADDR_W,
   parameter int DATA_W            = DEF_DATA_W,
   parameter int CLKS_PER_HALF_BIT = 2
) (
   input  logic               r_Clk,
   input  logic               r_Rst_n,
   spi_ram_streamer_if.master bus
);

   if (CLKS_PER_HALF_BIT < 2) begin : g_bad_half_bit
      $error("spi_ram_streamer: CLKS_PER_HALF_BIT must be 2 or more");
   end

   localparam int CNT_W = $clog2(CLKS_PER_HALF_BIT) + 1;
   localparam int BIT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(1);
   localparam logic [CNT_W-1:0] TAIL_LAST  = CNT_W'(CLKS_PER_HALF_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

   state_t            state, state_n;
   logic [CNT_W-1:0]  step_cnt;     // cycles spent in the current state
   logic [ADDR_W:0]   byte_cnt;     // bytes not yet loaded into the shifter
   logic [BIT_W-1:0]  bit_cnt;      // bit of the current byte on MOSI
   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] hold_q;       // prefetched next byte
   logic [1:0]        pf_pipe;      // RAM read latency tracker for prefetch
   logic [ADDR_W-1:0] addr_q;
   logic              busy_q, done_q, cs_n_q, mosi_q;

   logic sclk, rise, fall;
   logic accept, accept_zero, finish;
   logic more, byte_end, first_rise;

   assign more       = (byte_cnt != '0);
   assign byte_end   = fall && (bit_cnt == '0);
   assign first_rise = rise && (bit_cnt == BIT_LAST);

   spi_clk_gen #(
      .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
   ) u_clk_gen (
      .r_Clk   (r_Clk),
      .r_Rst_n (r_Rst_n),
      .en      (state == SHIFT),
      .sclk    (sclk),
      .rise    (rise),
      .fall    (fall)
   );

   // State register plus per-state cycle counter, cleared on every transition.
   always_ff @(posedge r_Clk or negedge r_Rst_n) begin
      if (!r_Rst_n) begin
         state    <= IDLE;
         step_cnt <= '0;
      end else begin
         state    <= state_n;
         step_cnt <= (state_n != state) ? '0 : step_cnt + CNT_W'(1);
      end
   end

   // Next-state decode and the one-cycle control strobes for the datapath.
   // NOTE: every output of this block gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_n     = state;
      accept      = 1'b0;
      accept_zero = 1'b0;
      finish      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.i_Start) begin
               if (bus.i_Length == '0) begin
                  accept_zero = 1'b1;
               end else begin
                  accept  = 1'b1;
                  state_n = FETCH;
               end
            end
         end
         FETCH: if (step_cnt == FETCH_LAST) state_n = LOAD;
         LOAD:  state_n = SHIFT;
         SHIFT: if (byte_end && !more) state_n = TAIL;
         TAIL: begin
            if (step_cnt == TAIL_LAST) begin
               finish  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Burst datapath: handshake outputs, RAM address, byte/bit counters and
   // the shift/holding registers.
   // NOTE: the shift and holding registers are ordinary flops, so they are
   // reset with everything else; only a true RAM array is left unreset.
   always_ff @(posedge r_Clk or negedge r_Rst_n) begin
      if (!r_Rst_n) begin
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cs_n_q   <= 1'b1;
         mosi_q   <= 1'b0;
         addr_q   <= '0;
         byte_cnt <= '0;
         bit_cnt  <= '0;
         shift_q  <= '0;
         hold_q   <= '0;
         pf_pipe  <= '0;
      end else begin
         done_q  <= accept_zero || finish;
         pf_pipe <= {pf_pipe[0], 1'b0};

         if (accept) begin
            busy_q   <= 1'b1;
            cs_n_q   <= 1'b0;
            addr_q   <= bus.i_Base_Address;
            byte_cnt <= bus.i_Length;
         end

         if (finish) begin
            busy_q <= 1'b0;
            cs_n_q <= 1'b1;
            mosi_q <= 1'b0;
         end

         if (state == LOAD) begin
            shift_q  <= bus.r_Data;
            mosi_q   <= bus.r_Data[DATA_W-1];
            byte_cnt <= byte_cnt - (ADDR_W+1)'(1);
            bit_cnt  <= BIT_LAST;
         end

         if (state == SHIFT) begin
            if (first_rise && more) begin
               addr_q  <= addr_q + ADDR_W'(1);
               pf_pipe <= {pf_pipe[0], 1'b1};
            end
            if (pf_pipe[1]) begin
               hold_q <= bus.r_Data;
            end
            if (fall) begin
               if (bit_cnt != '0) begin
                  shift_q <= {shift_q[DATA_W-2:0], 1'b0};
                  mosi_q  <= shift_q[DATA_W-2];
                  bit_cnt <= bit_cnt - BIT_W'(1);
               end else if (more) begin
                  shift_q  <= hold_q;
                  mosi_q   <= hold_q[DATA_W-1];
                  byte_cnt <= byte_cnt - (ADDR_W+1)'(1);
                  bit_cnt  <= BIT_LAST;
               end
            end
         end
      end
   end

   assign bus.r_Address  = addr_q;
   assign bus.o_Busy     = busy_q;
   assign bus.o_Done     = done_q;
   assign bus.o_SPI_Clk  = sclk;
   assign bus.o_SPI_MOSI = mosi_q;
   assign bus.o_SPI_CS_n = cs_n_q;

endmodule

// File: tb/tb_spi_ram_streamer.sv
// tb_spi_ram_streamer: directed bench for spi_ram_streamer with a registered
// read RAM preloaded mem[i] = i[7:0] and an SPI target that decodes MOSI on
// SCLK rises.
module tb_spi_ram_streamer;

   localparam int ADDR_W  = 10;
   localparam int DATA_W  = 8;
   localparam int CPH     = 2;
   localparam int BIT_CYC = 2 * CPH;

   logic r_Clk   = 1'b0;
   logic r_Rst_n = 1'b0;

   spi_ram_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sif ();

   spi_ram_streamer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLKS_PER_HALF_BIT(CPH)
   ) dut (
      .r_Clk   (r_Clk),
      .r_Rst_n (r_Rst_n),
      .bus     (sif)
   );

   always #5 r_Clk = ~r_Clk;

   // Buffer RAM read port: data valid one cycle after the address is sampled.
   logic [7:0] mem [0:1023];
   always @(posedge r_Clk) sif.r_Data <= mem[sif.r_Address];

   int n_vec  = 0;
   int n_miss = 0;

   // Monitor state, sampled on the falling clock edge.
   int cyc = 0, rise_cnt = 0, gap_err = 0, cs_err = 0, done_cnt = 0;
   int first_rise_cyc = 0, rises_in_burst = 0, last_rise = 0;
   int busy_rise_cnt = 0, cs_fall_cnt = 0, nbits = 0;
   logic prev_sclk = 1'b0, prev_cs_n = 1'b1, prev_busy = 1'b0;
   logic [9:0] prev_addr = '0;
   logic [7:0] sh = '0;
   logic [7:0] rx_q[$];
   logic [9:0] addr_log[$];

   initial begin
      forever begin
         @(negedge r_Clk);
         cyc++;
         if (!r_Rst_n) begin
            prev_sclk = 1'b0;
            prev_cs_n = 1'b1;
            prev_busy = 1'b0;
            nbits     = 0;
         end else begin
            if (!sif.o_SPI_CS_n && prev_cs_n) begin
               cs_fall_cnt++;
               rises_in_burst = 0;
            end
            if (sif.o_SPI_Clk && !prev_sclk) begin
               rise_cnt++;
               if (rises_in_burst > 0 && (cyc - last_rise) != BIT_CYC) gap_err++;
               if (rises_in_burst == 0) first_rise_cyc = cyc;
               rises_in_burst++;
               last_rise = cyc;
               sh = {sh[6:0], sif.o_SPI_MOSI};
               nbits++;
               if (nbits == 8) begin
                  rx_q.push_back(sh);
                  nbits = 0;
               end
            end
            if (sif.o_Busy == sif.o_SPI_CS_n) cs_err++;
            if (sif.o_SPI_Clk && sif.o_SPI_CS_n) cs_err++;
            if (sif.o_Busy && (!prev_busy || sif.r_Address != prev_addr))
               addr_log.push_back(sif.r_Address);
            if (sif.o_Busy && !prev_busy) busy_rise_cnt++;
            if (sif.o_Done) done_cnt++;
            prev_sclk = sif.o_SPI_Clk;
            prev_cs_n = sif.o_SPI_CS_n;
            prev_busy = sif.o_Busy;
            prev_addr = sif.r_Address;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge r_Clk);
      #1;
   endtask

   // Presents a start request; returns the monitor cycle just after it was sampled.
   task automatic start_burst(input logic [9:0] base, input logic [10:0] len, output int k1);
      sif.i_Base_Address = base;
      sif.i_Length       = len;
      sif.i_Start        = 1'b1;
      tick();
      sif.i_Start = 1'b0;
      k1 = cyc;
   endtask

   // Waits (bounded) for o_Done; k is the done cycle counted from k1 = 1.
   task automatic wait_done(input string tag, input int k1, input int limit, output int k);
      int n;
      n = 0;
      while (sif.o_Done !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      check({tag, "_done_seen"}, 32'(sif.o_Done), 32'd1);
      k = cyc - k1 + 1;
   endtask

   task automatic check_rx(input string tag, input logic [9:0] base, input int len);
      logic [7:0] e;
      check({tag, "_byte_count"}, rx_q.size(), len);
      for (int i = 0; i < len && i < rx_q.size(); i++) begin
         e = 8'(int'(base) + i);
         check($sformatf("%s_byte%0d", tag, i), rx_q[i], e);
      end
   endtask

   function automatic int burst_cycles(input int n);
      return 3 + n * 2 * DATA_W * CPH + CPH + 1;
   endfunction

   initial begin
      int k1, k, r0, d0, g0, c0, b0, f0;

      for (int i = 0; i < 1024; i++) mem[i] = i[7:0];
      sif.i_Start        = 1'b0;
      sif.i_Base_Address = '0;
      sif.i_Length       = '0;

      // Reset state.
      repeat (3) tick();
      check("rst_cs_n", sif.o_SPI_CS_n, 1);
      check("rst_sclk", sif.o_SPI_Clk, 0);
      check("rst_mosi", sif.o_SPI_MOSI, 0);
      check("rst_busy", sif.o_Busy, 0);
      check("rst_done", sif.o_Done, 0);
      check("rst_addr", sif.r_Address, 0);
      r_Rst_n = 1'b1;
      repeat (2) tick();

      // Three bytes from 0x010.
      rx_q.delete(); addr_log.delete();
      r0 = rise_cnt; d0 = done_cnt; g0 = gap_err; c0 = cs_err;
      start_burst(10'h010, 11'd3, k1);
      check("t1_cs_fall", sif.o_SPI_CS_n, 0);
      check("t1_busy", sif.o_Busy, 1);
      wait_done("t1", k1, 500, k);
      check("t1_cycles", k, burst_cycles(3));
      check("t1_first_rise", first_rise_cyc - k1 + 1, 3 + CPH + 1);
      check_rx("t1", 10'h010, 3);
      check("t1_sclk_pulses", rise_cnt - r0, 24);
      check("t1_sclk_gap", gap_err - g0, 0);
      check("t1_cs_busy", cs_err - c0, 0);
      tick();
      check("t1_done_width", sif.o_Done, 0);
      check("t1_busy_after", sif.o_Busy, 0);
      check("t1_cs_after", sif.o_SPI_CS_n, 1);
      check("t1_done_count", done_cnt - d0, 1);

      // Address wrap 0x3FE..0x001.
      rx_q.delete(); addr_log.delete();
      start_burst(10'h3FE, 11'd4, k1);
      wait_done("t2", k1, 500, k);
      check("t2_cycles", k, burst_cycles(4));
      check_rx("t2", 10'h3FE, 4);
      check("t2_addr_count", addr_log.size(), 4);
      if (addr_log.size() == 4) begin
         check("t2_addr0", addr_log[0], 10'h3FE);
         check("t2_addr1", addr_log[1], 10'h3FF);
         check("t2_addr2", addr_log[2], 10'h000);
         check("t2_addr3", addr_log[3], 10'h001);
      end
      tick();

      // Zero length: done only, nothing on the SPI pins.
      r0 = rise_cnt; d0 = done_cnt; b0 = busy_rise_cnt; f0 = cs_fall_cnt;
      start_burst(10'h0AA, 11'd0, k1);
      check("t3_done_lat", sif.o_Done, 1);
      check("t3_busy", sif.o_Busy, 0);
      check("t3_cs_n", sif.o_SPI_CS_n, 1);
      tick();
      check("t3_done_width", sif.o_Done, 0);
      repeat (10) tick();
      check("t3_sclk_quiet", rise_cnt - r0, 0);
      check("t3_cs_quiet", cs_fall_cnt - f0, 0);
      check("t3_busy_quiet", busy_rise_cnt - b0, 0);
      check("t3_done_count", done_cnt - d0, 1);

      // Start mid-burst is ignored; start in the done cycle chains a burst.
      rx_q.delete();
      start_burst(10'h020, 11'd2, k1);
      repeat (20) tick();
      sif.i_Base_Address = 10'h100;
      sif.i_Length       = 11'd5;
      sif.i_Start        = 1'b1;
      tick();
      sif.i_Start = 1'b0;
      check("t4_busy_hold", sif.o_Busy, 1);
      wait_done("t4a", k1, 500, k);
      check("t4a_cycles", k, burst_cycles(2));
      check("t4_cs_gap_high", sif.o_SPI_CS_n, 1);
      check_rx("t4a", 10'h020, 2);
      rx_q.delete();
      start_burst(10'h040, 11'd1, k1);
      check("t4_cs_gap_len", sif.o_SPI_CS_n, 0);
      wait_done("t4b", k1, 500, k);
      check("t4b_cycles", k, burst_cycles(1));
      check_rx("t4b", 10'h040, 1);
      tick();

      // Reset mid-byte, then a clean burst from a new base.
      start_burst(10'h050, 11'd3, k1);
      repeat (29) tick();
      check("t5_pre_cs", sif.o_SPI_CS_n, 0);
      r_Rst_n = 1'b0;
      #1;
      check("t5_rst_cs_n", sif.o_SPI_CS_n, 1);
      check("t5_rst_sclk", sif.o_SPI_Clk, 0);
      check("t5_rst_mosi", sif.o_SPI_MOSI, 0);
      check("t5_rst_busy", sif.o_Busy, 0);
      check("t5_rst_addr", sif.r_Address, 0);
      repeat (2) tick();
      r_Rst_n = 1'b1;
      r0 = rise_cnt;
      repeat (6) tick();
      check("t5_idle_sclk", rise_cnt - r0, 0);
      check("t5_idle_busy", sif.o_Busy, 0);
      rx_q.delete();
      start_burst(10'h123, 11'd2, k1);
      wait_done("t5", k1, 500, k);
      check("t5_cycles", k, burst_cycles(2));
      check_rx("t5", 10'h123, 2);
      tick();

      // Full 1024-byte buffer, starting mid-buffer.
      rx_q.delete(); addr_log.delete();
      d0 = done_cnt; g0 = gap_err; c0 = cs_err;
      start_burst(10'h155, 11'd1024, k1);
      wait_done("t6", k1, 40000, k);
      check("t6_cycles", k, burst_cycles(1024));
      check_rx("t6", 10'h155, 1024);
      check("t6_addr_count", addr_log.size(), 1024);
      if (addr_log.size() == 1024) begin
         check("t6_addr_first", addr_log[0], 10'h155);
         check("t6_addr_last", addr_log[1023], 10'h154);
      end
      check("t6_sclk_gap", gap_err - g0, 0);
      check("t6_cs_busy", cs_err - c0, 0);
      repeat (5) tick();
      check("t6_done_count", done_cnt - d0, 1);
      check("t6_busy_after", sif.o_Busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
